// File: rtl/b4_rr_arbiter_if.sv
// Request/grant bundle between four bus requesters and the round-robin arbiter.
// The master side is the requester pool and the slave side is the arbiter.
interface b4_rr_arbiter_if;
    logic [3:0] req3_req0;
    logic [3:0] gnt3_gnt0;
    logic [1:0] b1_b0;
    logic       valid;

    modport master (
        output req3_req0,
        input  gnt3_gnt0,
        input  b1_b0,
        input  valid
    );

    modport slave (
        input  req3_req0,
        output gnt3_gnt0,
        output b1_b0,
        output valid
    );
endinterface

// File: rtl/b4_rr_arbiter.sv
// Four-source round-robin arbiter for a shared tristate bus, with a bounded hold
// time and a one-cycle no-owner turnaround between successive owners.
module b4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic           clock,
    input  logic           reset_,
    b4_rr_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT  = 2'd1;
    localparam logic [1:0] SWITCH = 2'd2;

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    logic [1:0] state_q, state_d;
    logic [3:0] gnt_q,   gnt_d;
    logic [1:0] idx_q,   idx_d;
    logic       valid_q, valid_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [1:0] last_q,  last_d;

    logic       found;
    logic [1:0] win;
    logic       others_req;
    logic       owner_req;

    // Walk the search order backwards so the nearest candidate after last wins;
    // offset 4 wraps to last itself, which therefore has the lowest priority.
    function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] r;
        logic [1:0] cand;
        r = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                r = {1'b1, cand};
            end
        end
        return r;
    endfunction

    assign {found, win} = pick(bus.req3_req0, last_q);
    assign owner_req    = bus.req3_req0[idx_q];
    assign others_req   = |(bus.req3_req0 & ~gnt_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE, SWITCH: begin
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << win;
                    idx_d   = win;
                    valid_d = 1'b1;
                    cnt_d   = 4'd1;
                    last_d  = win;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // Release is checked first so it also covers the hold-limit edge.
                if (!owner_req || (cnt_q == MAX_HOLD_C && others_req)) begin
                    state_d = SWITCH;
                    gnt_d   = 4'b0000;
                    valid_d = 1'b0;
                    cnt_d   = 4'd0;
                    last_d  = idx_q;
                end else if (cnt_q < MAX_HOLD_C) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                valid_d = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
            cnt_q   <= 4'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign bus.gnt3_gnt0 = gnt_q;
    assign bus.b1_b0     = idx_q;
    assign bus.valid     = valid_q;
endmodule
